shared_mem_arbiter: RTL and testbench

SHARED_MEM_ARBITER -- requirements
Module: shared_mem_arbiter

---
 rtl/shared_mem_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_shared_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_mem_arbiter.sv
// Shared memory arbiter: serialises instruction fetches and data accesses onto
// a single memory port, one transaction at a time. Data has priority, but a
// waiting fetch is forced through after STARVE_LIMIT consecutive data grants.
module shared_mem_arbiter #(
  parameter int ADDRESS_BITS = 20,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  // Instruction fetch port
  input  logic                      i_req,
  input  logic [ADDRESS_BITS-1:0]   i_addr,
  output logic                      i_resp_valid,
  output logic [DATA_WIDTH-1:0]     i_resp_data,
  // Data port
  input  logic                      d_read,
  input  logic                      d_write,
  input  logic [ADDRESS_BITS-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]     d_wdata,
  input  logic [DATA_WIDTH/8-1:0]   d_byte_en,
  output logic                      d_resp_valid,
  output logic [DATA_WIDTH-1:0]     d_resp_data,
  // Shared memory port
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [ADDRESS_BITS-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_byte_en,
  input  logic                      mem_ready,
  input  logic                      mem_valid,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  // Stall indications to the core
  output logic                      i_mem_hazard,
  output logic                      d_mem_issue_hazard,
  output logic                      d_mem_recv_hazard
);

  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(STARVE_LIMIT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE_I = 3'd1,
    WAIT_I  = 3'd2,
    ISSUE_D = 3'd3,
    WAIT_D  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    starve_cnt_q, starve_cnt_d;
  // The mem_* command registers double as the grant latch for the transaction.
  logic                    mem_read_q, mem_read_d;
  logic                    mem_write_q, mem_write_d;
  logic [ADDRESS_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BE_WIDTH-1:0]     mem_byte_en_q, mem_byte_en_d;
  logic                    i_resp_valid_q, i_resp_valid_d;
  logic [DATA_WIDTH-1:0]   i_resp_data_q, i_resp_data_d;
  logic                    d_resp_valid_q, d_resp_valid_d;
  logic [DATA_WIDTH-1:0]   d_resp_data_q, d_resp_data_d;
  logic                    d_req;

  assign d_req = d_read | d_write;

  // Next-state, grant decision, command hold and response capture.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; that is what keeps this block free of inferred latches.
    state_d        = state_q;
    starve_cnt_d   = starve_cnt_q;
    mem_read_d     = mem_read_q;
    mem_write_d    = mem_write_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_byte_en_d  = mem_byte_en_q;
    i_resp_valid_d = 1'b0;
    i_resp_data_d  = i_resp_data_q;
    d_resp_valid_d = 1'b0;
    d_resp_data_d  = d_resp_data_q;

    unique case (state_q)
      IDLE: begin
        if (!i_req) starve_cnt_d = '0;
        if (i_req && (!d_req || starve_cnt_q == CNT_LIMIT)) begin
          state_d       = ISSUE_I;
          starve_cnt_d  = '0;
          mem_read_d    = 1'b1;
          mem_write_d   = 1'b0;
          mem_addr_d    = i_addr;
          mem_wdata_d   = '0;
          mem_byte_en_d = '1;
        end else if (d_req) begin
          state_d       = ISSUE_D;
          if (i_req && starve_cnt_q != CNT_LIMIT) starve_cnt_d = starve_cnt_q + CNT_ONE;
          // A simultaneous read+write request is treated as a write.
          mem_read_d    = ~d_write;
          mem_write_d   = d_write;
          mem_addr_d    = d_addr;
          mem_wdata_d   = d_wdata;
          mem_byte_en_d = d_byte_en;
        end
      end
      ISSUE_I: begin
        if (mem_ready) begin
          mem_read_d = 1'b0;
          if (mem_valid) begin
            state_d        = IDLE;
            i_resp_valid_d = 1'b1;
            i_resp_data_d  = mem_rdata;
          end else begin
            state_d = WAIT_I;
          end
        end
      end
      WAIT_I: begin
        if (mem_valid) begin
          state_d        = IDLE;
          i_resp_valid_d = 1'b1;
          i_resp_data_d  = mem_rdata;
        end
      end
      ISSUE_D: begin
        if (mem_ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (mem_write_q) begin
            state_d        = IDLE;
            d_resp_valid_d = 1'b1;
          end else if (mem_valid) begin
            state_d        = IDLE;
            d_resp_valid_d = 1'b1;
            d_resp_data_d  = mem_rdata;
          end else begin
            state_d = WAIT_D;
          end
        end
      end
      WAIT_D: begin
        if (mem_valid) begin
          state_d        = IDLE;
          d_resp_valid_d = 1'b1;
          d_resp_data_d  = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and all registered outputs; reset clears everything.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      starve_cnt_q   <= '0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_byte_en_q  <= '0;
      i_resp_valid_q <= 1'b0;
      i_resp_data_q  <= '0;
      d_resp_valid_q <= 1'b0;
      d_resp_data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q        <= state_d;
      starve_cnt_q   <= starve_cnt_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_byte_en_q  <= mem_byte_en_d;
      i_resp_valid_q <= i_resp_valid_d;
      i_resp_data_q  <= i_resp_data_d;
      d_resp_valid_q <= d_resp_valid_d;
      d_resp_data_q  <= d_resp_data_d;
    end
  end

  assign mem_read     = mem_read_q;
  assign mem_write    = mem_write_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_byte_en  = mem_byte_en_q;
  assign i_resp_valid = i_resp_valid_q;
  assign i_resp_data  = i_resp_data_q;
  assign d_resp_valid = d_resp_valid_q;
  assign d_resp_data  = d_resp_data_q;

  // Stall indications are the only combinational outputs.
  assign i_mem_hazard       = i_req & ~i_resp_valid_q;
  assign d_mem_issue_hazard = d_req & (state_q != WAIT_D) & ~d_resp_valid_q;
  assign d_mem_recv_hazard  = (state_q == WAIT_D);

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Self-checking bench for shared_mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of the arbiter.
module tb_shared_mem_arbiter;

  localparam int AW    = 20;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int LIMIT = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_resp_valid;
  logic [DW-1:0] i_resp_data;
  logic          d_read = 1'b0, d_write = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [BW-1:0] d_byte_en = '0;
  logic          d_resp_valid;
  logic [DW-1:0] d_resp_data;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_byte_en;
  logic          mem_ready = 1'b0, mem_valid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          i_mem_hazard, d_mem_issue_hazard, d_mem_recv_hazard;

  always #5 clock = ~clock;

  shared_mem_arbiter #(
    .ADDRESS_BITS(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_byte_en(d_byte_en),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en),
    .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .i_mem_hazard(i_mem_hazard), .d_mem_issue_hazard(d_mem_issue_hazard),
    .d_mem_recv_hazard(d_mem_recv_hazard)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    bit            active;    // a transaction is outstanding
    bit            for_data;  // owner: data port (else fetch)
    bit            write;
    bit            accepted;  // memory took the command, waiting for data
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } txn_t;

  txn_t          cur;
  bit            m_i_pulse, m_d_pulse;
  logic [DW-1:0] m_i_data, m_d_data;
  int            m_waited;   // consecutive data grants while a fetch waited

  task automatic model_reset();
    cur.active = 0; cur.for_data = 0; cur.write = 0; cur.accepted = 0;
    cur.addr = '0; cur.wdata = '0; cur.be = '0;
    m_i_pulse = 0; m_d_pulse = 0; m_i_data = '0; m_d_data = '0; m_waited = 0;
  endtask

  task automatic complete(input logic [DW-1:0] data);
    if (cur.for_data) begin
      m_d_pulse = 1;
      if (!cur.write) m_d_data = data;
    end else begin
      m_i_pulse = 1;
      m_i_data  = data;
    end
    cur.active = 0;
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_step();
    bit dreq;
    dreq = d_read | d_write;
    m_i_pulse = 0;
    m_d_pulse = 0;
    if (!cur.active) begin
      if (!i_req) m_waited = 0;
      if (i_req && (!dreq || m_waited == LIMIT)) begin
        cur.active = 1; cur.for_data = 0; cur.write = 0; cur.accepted = 0;
        cur.addr = i_addr;
        m_waited = 0;
      end else if (dreq) begin
        cur.active = 1; cur.for_data = 1; cur.write = d_write; cur.accepted = 0;
        cur.addr = d_addr; cur.wdata = d_wdata; cur.be = d_byte_en;
        if (i_req && m_waited < LIMIT) m_waited++;
      end
    end else if (!cur.accepted) begin
      if (mem_ready) begin
        if (cur.write || mem_valid) complete(mem_rdata);
        else cur.accepted = 1;
      end
    end else if (mem_valid) begin
      complete(mem_rdata);
    end
  endtask

  // Compare process: just before each rising edge, check every output.
  always @(negedge clock) begin
    bit exp_cmd, wait_d;
    #4;
    if (!reset) model_reset();
    exp_cmd = cur.active && !cur.accepted;
    wait_d  = cur.active && cur.for_data && cur.accepted;
    check("mdl_mem_read",  mem_read,  exp_cmd && !cur.write);
    check("mdl_mem_write", mem_write, exp_cmd && cur.write);
    if (exp_cmd) begin
      check("mdl_mem_addr", mem_addr, cur.addr);
      if (cur.for_data) begin
        check("mdl_mem_wdata",   mem_wdata,   cur.wdata);
        check("mdl_mem_byte_en", mem_byte_en, cur.be);
      end
    end
    check("mdl_i_resp_valid", i_resp_valid, m_i_pulse);
    check("mdl_i_resp_data",  i_resp_data,  m_i_data);
    check("mdl_d_resp_valid", d_resp_valid, m_d_pulse);
    check("mdl_d_resp_data",  d_resp_data,  m_d_data);
    check("mdl_i_hazard",     i_mem_hazard, i_req && !m_i_pulse);
    check("mdl_d_issue_hazard", d_mem_issue_hazard, (d_read || d_write) && !wait_d && !m_d_pulse);
    check("mdl_d_recv_hazard",  d_mem_recv_hazard, wait_d);
    if (reset) model_step();
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge clock);
  endtask

  logic [AW-1:0] grants [$];
  logic [AW-1:0] exp_order [6];
  logic [AW-1:0] got;
  int            op;

  initial begin
    model_reset();

    // Reset state
    cyc(); #3;
    check("rst_mem_read",     mem_read, 1'b0);
    check("rst_mem_write",    mem_write, 1'b0);
    check("rst_mem_addr",     mem_addr, '0);
    check("rst_i_resp_valid", i_resp_valid, 1'b0);
    check("rst_d_resp_valid", d_resp_valid, 1'b0);
    check("rst_i_resp_data",  i_resp_data, '0);
    cyc(); #1 reset = 1'b1;
    cyc();

    // Fetch with separate accept and data cycles
    cyc(); i_req = 1; i_addr = 20'h00100; #3;
    check("fetch_hazard_c0", i_mem_hazard, 1'b1);
    check("fetch_no_cmd_c0", mem_read, 1'b0);
    cyc(); mem_ready = 1; #3;
    check("fetch_mem_read_c1", mem_read, 1'b1);
    check("fetch_mem_addr_c1", mem_addr, 20'h00100);
    cyc(); mem_ready = 0; #3;
    check("fetch_read_dropped_c2", mem_read, 1'b0);
    cyc(); mem_valid = 1; mem_rdata = 32'hDEADBEEF; #3;
    check("fetch_no_early_resp_c3", i_resp_valid, 1'b0);
    cyc(); mem_valid = 0; #3;
    check("fetch_resp_valid_c4", i_resp_valid, 1'b1);
    check("fetch_resp_data_c4", i_resp_data, 32'hDEADBEEF);
    check("fetch_hazard_clear_c4", i_mem_hazard, 1'b0);
    i_req = 0;
    cyc(); #3;
    check("fetch_pulse_one_cycle", i_resp_valid, 1'b0);
    check("fetch_data_held", i_resp_data, 32'hDEADBEEF);

    // Conflict and starvation override: D,D,D,D then I, then D again
    cyc();
    i_req = 1; i_addr = 20'h00AAA; d_read = 1; d_addr = 20'h00BBB;
    mem_ready = 1; mem_valid = 1; mem_rdata = 32'h5555AAAA;
    for (int c = 0; c < 16 && grants.size() < 6; c++) begin
      cyc(); #3;
      if (mem_read === 1'b1) grants.push_back(mem_addr);
    end
    i_req = 0; d_read = 0;
    cyc();
    cyc(); mem_ready = 0; mem_valid = 0;
    exp_order[0] = 20'h00BBB; exp_order[1] = 20'h00BBB; exp_order[2] = 20'h00BBB;
    exp_order[3] = 20'h00BBB; exp_order[4] = 20'h00AAA; exp_order[5] = 20'h00BBB;
    check("starve_grant_count", grants.size(), 6);
    for (int k = 0; k < 6; k++) begin
      got = (k < grants.size()) ? grants[k] : 'x;
      check($sformatf("starve_grant_%0d", k), got, exp_order[k]);
    end
    check("starve_d_data", d_resp_data, 32'h5555AAAA);

    // Write with delayed accept; inputs change after grant
    cyc(); d_write = 1; d_addr = 20'h00040; d_wdata = 32'h12345678; d_byte_en = 4'b0011; #3;
    check("wr_hazard_c0", d_mem_issue_hazard, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      cyc();
      d_addr = 20'hFFFFF; d_wdata = 32'hFFFFFFFF; d_byte_en = 4'b1100;
      mem_ready = (c == 4);
      #3;
      check($sformatf("wr_mem_write_c%0d", c), mem_write, 1'b1);
      check($sformatf("wr_mem_addr_c%0d", c), mem_addr, 20'h00040);
      check($sformatf("wr_mem_wdata_c%0d", c), mem_wdata, 32'h12345678);
      check($sformatf("wr_mem_be_c%0d", c), mem_byte_en, 4'b0011);
      check($sformatf("wr_hazard_c%0d", c), d_mem_issue_hazard, 1'b1);
      check($sformatf("wr_no_resp_c%0d", c), d_resp_valid, 1'b0);
    end
    cyc(); mem_ready = 0; #3;
    check("wr_resp_valid", d_resp_valid, 1'b1);
    check("wr_mem_write_dropped", mem_write, 1'b0);
    check("wr_hazard_clear", d_mem_issue_hazard, 1'b0);
    check("wr_d_data_unchanged", d_resp_data, 32'h5555AAAA);
    d_write = 0;
    cyc(); #3;
    check("wr_resp_one_pulse", d_resp_valid, 1'b0);

    // Same-cycle accept and data on a fetch
    cyc(); i_req = 1; i_addr = 20'h00222; #3;
    cyc(); mem_ready = 1; mem_valid = 1; mem_rdata = 32'hCAFEF00D; #3;
    check("same_mem_read", mem_read, 1'b1);
    cyc(); mem_ready = 0; mem_valid = 0; #3;
    check("same_resp_valid", i_resp_valid, 1'b1);
    check("same_resp_data", i_resp_data, 32'hCAFEF00D);
    i_req = 0;
    cyc(); #3;
    check("same_resp_one_pulse", i_resp_valid, 1'b0);

    // Reset during WAIT_D, then a stale mem_valid
    cyc(); d_read = 1; d_addr = 20'h00080; #3;
    cyc(); mem_ready = 1; #3;
    check("rmid_mem_read", mem_read, 1'b1);
    check("rmid_mem_addr", mem_addr, 20'h00080);
    cyc(); mem_ready = 0; #3;
    check("rmid_recv_hazard", d_mem_recv_hazard, 1'b1);
    check("rmid_issue_hazard", d_mem_issue_hazard, 1'b0);
    d_read = 0;
    cyc(); #1 reset = 0; #1;
    check("rmid_async_recv_hazard", d_mem_recv_hazard, 1'b0);
    check("rmid_async_mem_addr", mem_addr, '0);
    check("rmid_async_d_data", d_resp_data, '0);
    check("rmid_async_i_data", i_resp_data, '0);
    cyc(); mem_valid = 1; mem_rdata = 32'h0BADF00D; #1 reset = 1;
    cyc(); mem_valid = 0; #3;
    check("rmid_stale_ignored", d_resp_valid, 1'b0);
    check("rmid_stale_data", d_resp_data, '0);
    cyc(); #3;
    check("rmid_stale_ignored_late", d_resp_valid, 1'b0);

    // Randomized traffic, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      cyc();
      i_req     = ($urandom_range(0, 2) != 0);
      i_addr    = AW'($urandom);
      op        = $urandom_range(0, 2);
      d_read    = (op == 1);
      d_write   = (op == 2);
      d_addr    = AW'($urandom);
      d_wdata   = $urandom;
      d_byte_en = BW'($urandom);
      mem_ready = $urandom_range(0, 1);
      mem_valid = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      if ($urandom_range(0, 399) == 0) begin
        #1 reset = 0;
      end else if (!reset) begin
        #1 reset = 1;
      end
    end
    cyc(); #1 reset = 1;
    cyc(); cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
